// File: rtl/icache_port_arb.sv
// icache_port_arb: fetch/prefetch arbiter and response router for the icache port.
// Prefetch path is built only when ICACHE_ARB_PREFETCH_EN is defined.
module icache_port_arb #(
  parameter int LAT        = 3,
  parameter int STARVE_MAX = 4,
  parameter int BLK_W      = 26,
  parameter int LINE_W     = 64*8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic              f_get2,
  input  logic [BLK_W-1:0]  f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rsp,
  output logic [LINE_W-1:0] f_line0,
  output logic [LINE_W-1:0] f_line1,
  input  logic              p_req,
  input  logic [BLK_W-1:0]  p_addr,
  output logic              p_gnt,
  output logic              p_rsp,
  output logic              ic_req,
  output logic              ic_get2,
  output logic [BLK_W-1:0]  ic_addr,
  input  logic              ic_gnt,
  input  logic              ic_rsp,
  input  logic [LINE_W-1:0] ic_line0,
  input  logic [LINE_W-1:0] ic_line1,
  output logic              err
);
  localparam int GW = $clog2(LAT+1);

  logic [LAT-1:0] r_v;
  logic [LAT-1:0] r_own_f;
  logic [GW-1:0]  r_grace;
  logic           r_err;

  logic           w_fe;
  logic           w_pe;
  logic           w_fwin;
  logic           w_pwin;
  logic           w_merge;
  logic           w_acc;
  logic           w_t_v;
  logic           w_t_f;
  logic           w_t_p;
  logic           w_err_ev;
  logic [LAT:0]   w_v_sh;
  logic [LAT:0]   w_f_sh;

  assign w_fe = f_req & ~f_flush;

`ifdef ICACHE_ARB_PREFETCH_EN
  localparam int SW = $clog2(STARVE_MAX+1);

  logic [SW-1:0]  r_starve;
  logic [LAT-1:0] r_own_p;
  logic           w_conf;
  logic [LAT:0]   w_p_sh;

  assign w_pe    = p_req;
  assign w_merge = w_fe & w_pe & (p_addr == f_addr);
  assign w_conf  = w_fe & w_pe & ~w_merge;
  assign w_pwin  = w_pe & (~w_fe |
                   (w_conf & (r_starve == SW'(STARVE_MAX))));
  assign w_t_p   = r_own_p[LAT-1];
  assign w_p_sh  = {r_own_p, p_gnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_own_p  <= '0;
    end else begin
      r_own_p <= w_p_sh[LAT-1:0];
      if (p_gnt)
        r_starve <= '0;
      else if (w_conf & f_gnt &
               (r_starve != SW'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{p_req, p_addr, 32'(STARVE_MAX)};
  assign w_pe     = 1'b0;
  assign w_merge  = 1'b0;
  assign w_pwin   = 1'b0;
  assign w_t_p    = 1'b0;
`endif

  assign w_fwin = w_fe & ~w_pwin;
  assign w_acc  = ~rst & (w_fe | w_pe) & ic_gnt;
  assign w_t_v  = r_v[LAT-1];
  assign w_t_f  = r_own_f[LAT-1];
  assign w_v_sh = {r_v, w_acc};
  // a flush strips fetch ownership from everything in flight
  assign w_f_sh = {r_own_f & ~{LAT{f_flush}}, f_gnt};

  // stale responses from before reset are tolerated while r_grace runs
  assign w_err_ev = (ic_rsp & ~w_t_v & (r_grace == '0)) |
                    (w_t_v & ~ic_rsp);

  always_comb begin
    f_gnt   = 1'b0;
    p_gnt   = 1'b0;
    f_rsp   = 1'b0;
    p_rsp   = 1'b0;
    ic_req  = 1'b0;
    ic_get2 = 1'b0;
    ic_addr = '0;
    if (!rst) begin
      ic_req = w_fe | w_pe;
      unique case (1'b1)
        w_fwin: begin
          ic_addr = f_addr;
          ic_get2 = f_get2;
        end
        w_pwin: ic_addr = p_addr;
        default: ;
      endcase
      f_gnt = w_fwin & ic_gnt;
      p_gnt = (w_pwin | w_merge) & ic_gnt;
      f_rsp = ic_rsp & w_t_v & w_t_f & ~f_flush;
      p_rsp = ic_rsp & w_t_v & w_t_p;
    end
  end

  assign f_line0 = ic_line0;
  assign f_line1 = ic_line1;
  assign err     = r_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_own_f <= '0;
      r_grace <= GW'(LAT);
      r_err   <= 1'b0;
    end else begin
      r_v     <= w_v_sh[LAT-1:0];
      r_own_f <= w_f_sh[LAT-1:0];
      if (r_grace != '0)
        r_grace <= r_grace - 1'b1;
      if (w_err_ev)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_port_arb.sv
// tb_icache_port_arb: vector table plus response scoreboard for icache_port_arb.
// Expectations follow the build selected by ICACHE_ARB_PREFETCH_EN.
module tb_icache_port_arb;
  localparam int LAT = 3;
  localparam int BW  = 26;
  localparam int LW  = 512;

  typedef struct {
    bit          r;
    bit          inj;
    bit          drop;
    bit          fr;
    bit          g2;
    bit          fl;
    bit          pr;
    bit          gnt;
    logic [BW-1:0] fa;
    logic [BW-1:0] pa;
    bit          efg;
    bit          epg;
    bit          ereq;
    bit          eg2;
    logic [BW-1:0] eaddr;
  } vec_t;

  typedef struct {
    int          due;
    bit          ef;
    bit          ep;
    logic [LW-1:0] l0;
    logic [LW-1:0] l1;
  } exp_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          f_req = 0;
  logic          f_get2 = 0;
  logic [BW-1:0] f_addr = '0;
  logic          f_flush = 0;
  logic          f_gnt;
  logic          f_rsp;
  logic [LW-1:0] f_line0;
  logic [LW-1:0] f_line1;
  logic          p_req = 0;
  logic [BW-1:0] p_addr = '0;
  logic          p_gnt;
  logic          p_rsp;
  logic          ic_req;
  logic          ic_get2;
  logic [BW-1:0] ic_addr;
  logic          ic_gnt = 0;
  logic          ic_rsp = 0;
  logic [LW-1:0] ic_line0 = '0;
  logic [LW-1:0] ic_line1 = '0;
  logic          err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exp_err = 0;
  exp_t q[$];
  vec_t tbl[$];

  icache_port_arb #(
    .LAT(LAT), .STARVE_MAX(4), .BLK_W(BW), .LINE_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_get2(f_get2), .f_addr(f_addr),
    .f_flush(f_flush), .f_gnt(f_gnt), .f_rsp(f_rsp),
    .f_line0(f_line0), .f_line1(f_line1),
    .p_req(p_req), .p_addr(p_addr),
    .p_gnt(p_gnt), .p_rsp(p_rsp),
    .ic_req(ic_req), .ic_get2(ic_get2), .ic_addr(ic_addr),
    .ic_gnt(ic_gnt), .ic_rsp(ic_rsp),
    .ic_line0(ic_line0), .ic_line1(ic_line1),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [LW-1:0] a,
                     input logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", n, cyc, a, e);
    end
  endtask

  function automatic vec_t mk(bit fr, bit g2, logic [BW-1:0] fa,
                              bit fl, bit pr, logic [BW-1:0] pa,
                              bit gnt, bit efg, bit epg, bit ereq,
                              logic [BW-1:0] eaddr, bit eg2);
    vec_t v;
    v.r = 0; v.inj = 0; v.drop = 0;
    v.fr = fr; v.g2 = g2; v.fa = fa; v.fl = fl;
    v.pr = pr; v.pa = pa; v.gnt = gnt;
    v.efg = efg; v.epg = epg; v.ereq = ereq;
    v.eaddr = eaddr; v.eg2 = eg2;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  // conflict 0x10 vs 0x20; epg selects which side is expected to win
  function automatic vec_t conf(bit gnt, bit efg, bit epg);
    return mk(1, 1, 'h10, 0, 1, 'h20, gnt, efg, epg, 1,
              epg ? BW'('h20) : BW'('h10), !epg);
  endfunction

  function automatic vec_t merge80();
    return mk(1, 1, 'h80, 0, 1, 'h80, 1, 1, 1, 1, 'h80, 1);
  endfunction

  // without the prefetch path only fetch can ever be selected
  function automatic vec_t adj(vec_t v);
`ifndef ICACHE_ARB_PREFETCH_EN
    bit fe;
    fe     = v.fr & ~v.fl;
    v.epg  = 0;
    v.efg  = fe & v.gnt;
    v.ereq = fe;
    v.eaddr = v.fa;
    v.eg2  = v.g2;
`endif
    return v;
  endfunction

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] r;
    for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick(input vec_t v0);
    vec_t v;
    exp_t e;
    bit now;
    bit efr;
    bit epr;
    v = adj(v0);
    if (v.r) begin
      v.efg = 0; v.epg = 0; v.ereq = 0;
    end
    now = (q.size() > 0) && (q[0].due == cyc);
    if (v.fl || v.r) foreach (q[i]) q[i].ef = 0;
    if (v.r) foreach (q[i]) q[i].ep = 0;
    rst = v.r; f_req = v.fr; f_get2 = v.g2; f_addr = v.fa;
    f_flush = v.fl; p_req = v.pr; p_addr = v.pa; ic_gnt = v.gnt;
    ic_rsp = (now && !v.drop) || v.inj;
    if (now) begin
      ic_line0 = q[0].l0;
      ic_line1 = q[0].l1;
    end
    @(negedge clk);
    efr = now && !v.drop && q[0].ef;
    epr = now && !v.drop && q[0].ep;
    chk("f_gnt", LW'(f_gnt), LW'(v.efg));
    chk("p_gnt", LW'(p_gnt), LW'(v.epg));
    chk("ic_req", LW'(ic_req), LW'(v.ereq));
    if (v.ereq) begin
      chk("ic_addr", LW'(ic_addr), LW'(v.eaddr));
      chk("ic_get2", LW'(ic_get2), LW'(v.eg2));
    end
    chk("f_rsp", LW'(f_rsp), LW'(efr));
    chk("p_rsp", LW'(p_rsp), LW'(epr));
    if (efr) begin
      chk("f_line0", f_line0, q[0].l0);
      chk("f_line1", f_line1, q[0].l1);
    end
    chk("err", LW'(err), LW'(v.r ? 1'b0 : exp_err));
    if (now) void'(q.pop_front());
    if (v.efg || v.epg) begin
      e.due = cyc + LAT; e.ef = v.efg; e.ep = v.epg;
      e.l0 = rline(); e.l1 = rline();
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (v.r) exp_err = 0;
    else if ((v.inj && !now) || (now && v.drop)) exp_err = 1;
  endtask

  vec_t rv;

  initial begin
    rv = mk(1, 1, 'h40, 0, 1, 'h40, 1, 0, 0, 0, 0, 0);
    rv.r = 1;

    tbl.push_back(mk(1, 1, 'h40, 0, 0, 0, 1, 1, 0, 1, 'h40, 1));
    tbl.push_back(idle());
    tbl.push_back(idle());
    tbl.push_back(mk(0, 1, 0, 0, 1, 'h55, 1, 0, 1, 1, 'h55, 0));
    tbl.push_back(merge80());
    tbl.push_back(mk(1, 0, 'h41, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h42, 1, 1, 'h33, 1, 0, 1, 1, 'h33, 0));
    tbl.push_back(mk(1, 0, 'h7F, 0, 0, 0, 1, 1, 0, 1, 'h7F, 0));
    tbl.push_back(mk(1, 1, 'h41, 0, 0, 0, 0, 0, 0, 1, 'h41, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h12, 0, 0, 0, 1, 'h12, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(idle());

    @(posedge clk);
    #1;
    tick(rv);
    tick(rv);

    foreach (tbl[i]) tick(tbl[i]);

    // starvation with stalls that must not advance the count
    tick(conf(1, 1, 0));
    tick(conf(1, 1, 0));
    tick(conf(0, 0, 0));
    tick(conf(0, 0, 0));
    tick(conf(1, 1, 0));
    tick(conf(1, 1, 0));
    tick(conf(1, 0, 1));
    // a merge grants prefetch and restarts the count
    tick(conf(1, 1, 0));
    tick(conf(1, 1, 0));
    tick(merge80());
    for (int i = 0; i < 4; i++) tick(conf(1, 1, 0));
    tick(conf(1, 0, 1));
    for (int i = 0; i < 4; i++) tick(idle());

    // flush squashes two in-flight fetches
    tick(mk(1, 1, 'h50, 0, 0, 0, 1, 1, 0, 1, 'h50, 1));
    tick(mk(1, 1, 'h51, 0, 0, 0, 1, 1, 0, 1, 'h51, 1));
    tick(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tick(idle());

    // flush in the very cycle the response returns
    tick(mk(1, 0, 'h60, 0, 0, 0, 1, 1, 0, 1, 'h60, 0));
    tick(idle());
    tick(idle());
    tick(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tick(idle());

    // spurious response sets a sticky error
    rv.inj = 0;
    begin
      vec_t vi;
      vi = idle();
      vi.inj = 1;
      tick(vi);
    end
    for (int i = 0; i < 3; i++) tick(idle());
    tick(rv);
    for (int i = 0; i < 4; i++) tick(idle());

    // reset mid-flight: stale responses are swallowed quietly
    tick(mk(1, 1, 'h70, 0, 0, 0, 1, 1, 0, 1, 'h70, 1));
    tick(mk(1, 1, 'h71, 0, 0, 0, 1, 1, 0, 1, 'h71, 1));
    tick(rv);
    for (int i = 0; i < 5; i++) tick(idle());

    // missing response sets the error too
    tick(mk(1, 0, 'h90, 0, 0, 0, 1, 1, 0, 1, 'h90, 0));
    tick(idle());
    tick(idle());
    begin
      vec_t vd;
      vd = idle();
      vd.drop = 1;
      tick(vd);
    end
    tick(idle());
    tick(idle());
    tick(rv);
    tick(mk(1, 1, 'hA0, 0, 0, 0, 1, 1, 0, 1, 'hA0, 1));
    for (int i = 0; i < 4; i++) tick(idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_port_arb.md
# icache_port_arb

Fetch/prefetch arbiter and response router for the instruction cache's single core-side port. Sits between the frontend fetch unit, the instruction prefetcher and `icache`. It shares the icache request port between both requesters, tracks every granted request through the icache's fixed 3-stage pipe, and routes each `rsp` back to its owner. It also squashes fetch responses on a frontend flush.

## Interface
Parameters:
- `LAT`, 3: icache request-to-`rsp` latency in cycles; also the tracker depth.
- `STARVE_MAX`, 4: conflict losses after which prefetch wins the next conflict.
- `LINE_W`, `CACHELINE_SIZE*8`: width of one cache line.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `f_req` in 1: fetch request.
- `f_get2` in 1: fetch wants line `addr` and line `addr+1`.
- `f_addr` in `BLKDEF`: fetch block address.
- `f_flush` in 1: frontend redirect.
- `f_gnt` out 1: fetch request accepted.
- `f_rsp` out 1: fetch response valid.
- `f_line0` out `LINE_W`: first line.
- `f_line1` out `LINE_W`: second line.
- `p_req` in 1: prefetch request.
- `p_addr` in `BLKDEF`: prefetch block address.
- `p_gnt` out 1: prefetch accepted.
- `p_rsp` out 1: prefetch completed.
- `ic_req` out 1: icache request.
- `ic_get2` out 1: icache get2.
- `ic_addr` out `BLKDEF`: icache address.
- `ic_gnt` in 1: icache accepted.
- `ic_rsp` in 1: icache response.
- `ic_line0` in `LINE_W`: icache line data.
- `ic_line1` in `LINE_W`: icache line data.
- `err` out 1: sticky protocol error.

## Operation
- **Eligibility.** Fetch is eligible when `f_req & ~f_flush`. Prefetch is eligible when `p_req`.
- **Selection.** Combinational, in this order:
  - Fetch only eligible: fetch wins.
  - Prefetch only eligible: prefetch wins.
  - Both eligible, `p_addr==f_addr`: merge. Fetch wins and the prefetch is also granted.
  - Both eligible, addresses differ: fetch wins, unless `starve_cnt==STARVE_MAX`, in which case prefetch wins.
- **Issue.**
  - `ic_req` is 1 when any requester is eligible.
  - `ic_addr` and `ic_get2` come from the winner; `ic_get2` is 0 for prefetch.
  - `f_gnt` = fetch won & `ic_gnt`.
  - `p_gnt` = (prefetch won or merged) & `ic_gnt`.
- **Starvation counter `starve_cnt`** (range 0..`STARVE_MAX`):
  - Increments when a non-merged conflict cycle grants fetch.
  - Clears on any `p_gnt`.
  - Holds otherwise, including when `ic_gnt=0`.
- **Tracker.** `LAT`-entry shift pipe advancing every cycle. Each entry holds {`v`, `own_f`, `own_p`}.
  - The entry entering the pipe is valid iff `ic_req & ic_gnt`.
  - `own_f` is set when fetch was granted; `own_p` when prefetch was granted or merged.
- **Flush.** `f_flush` clears `own_f` in every tracker entry in the same cycle. The entry entering that cycle cannot carry `own_f`, because fetch is ineligible during a flush.
- **Response routing** (combinational, tracker tail `t`):
  - `f_rsp` = `ic_rsp & t.v & t.own_f`.
  - `p_rsp` = `ic_rsp & t.v & t.own_p`.
  - `f_line0`/`f_line1` pass `ic_line0`/`ic_line1` straight through. Their value is meaningful only when `f_rsp=1`.
  - A fully squashed entry (`v=1`, no owner) consumes its `ic_rsp` silently.
- **Protocol errors.** `err` sets, and stays set until `rst`, on either of:
  - `ic_rsp=1` while `t.v=0`;
  - `t.v=1` while `ic_rsp=0`.

## Timing
- **Reset values:** `f_gnt`, `f_rsp`, `p_gnt`, `p_rsp`, `ic_req`, `ic_get2` and `err` are 0; `ic_addr` is 0; all tracker entries are invalid; `starve_cnt` is 0. The combinational outputs are forced to these values while `rst=1`.
- Grant is same-cycle. The response appears exactly `LAT` cycles after the grant cycle (grant at cycle N, `rsp` at N+`LAT`).
- Throughput is one grant per cycle. There is no outstanding-request limit beyond the `LAT` pipe entries.
- **Reset mid-operation:** the tracker is cleared. `rsp` pulses from requests issued before reset are consumed without raising `err`, for `LAT` cycles after reset deasserts.
- A flush and a response for a squashed fetch entry arriving in the same cycle yield `f_rsp=0`.

## Configuration
- `ICACHE_ARB_PREFETCH_EN` defined: full behaviour as above.
- `ICACHE_ARB_PREFETCH_EN` undefined:
  - The prefetch ports remain, but `p_req`/`p_addr` are ignored and `p_gnt`/`p_rsp` are constant 0.
  - `starve_cnt` and `own_p` are not built.
  - `ic_req` = `f_req & ~f_flush`.

## Test plan
- **Fetch only:** `f_req=1`, `f_addr=0x40`, `f_get2=1` at cycle 0, `ic_gnt=1` → `f_gnt=1` at cycle 0; `ic_addr=0x40`, `ic_get2=1`; `f_rsp=1` at cycle 3 with line data passed through.
- **Starvation:** continuous conflicts, `f_addr=0x10`, `p_addr=0x20` → fetch is granted on 4 cycles, prefetch on the 5th; `p_rsp` arrives 3 cycles later; `starve_cnt` returns to 0.
- **Merge:** `f_addr=p_addr=0x80` in the same cycle → `f_gnt=p_gnt=1` with one icache request; 3 cycles later `f_rsp=p_rsp=1`.
- **Flush:** fetch granted at cycles 0 and 1, `f_flush=1` at cycle 2 → `ic_rsp` at cycles 3 and 4 produce `f_rsp=0`; `err=0`.
- **Backpressure:** `ic_gnt=0` with both requesting → no grants, `starve_cnt` unchanged, no tracker entry.
- **Protocol error and reset:** inject `ic_rsp=1` with an empty tracker → `err=1` and held; `rst` clears it. Built without `ICACHE_ARB_PREFETCH_EN`: `p_req=1` → `p_gnt` stays 0.
